mmio_initiator: RTL and testbench
=================================

Name: mmio_initiator

Overview:
- CPU-side master for the MMIO bus; the peripheral blocks (seg7, switches, UART, …) are its responders.
- Accepts one load/store request from the memory stage and drives mmio_read/mmio_write/mmio_addr/mmio_write_data.
- Waits for the OR-reduced mmio_done from the selected responder and returns read data or an error.
- Catches unmapped addresses (no responder asserts mmio_work) and hung responders (timeout).

Parameters:
- TIMEOUT, 16, max cycles spent in ACCESS before an error response; must be >= 2.
- ERR_RDATA, 32'h0000_0000, value returned on resp_rdata when resp_err=1.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_we  in  1  1=store, 0=load
- req_addr  in  32  word address
- req_wdata  in  32  store data
- req_ready  out  1  initiator can accept a request this cycle
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  load data, or ERR_RDATA on error
- resp_err  out  1  unmapped or timed-out access
- mmio_read  out  1  bus read strobe
- mmio_write  out  1  bus write strobe
- mmio_addr  out  32  bus address
- mmio_write_data  out  32  bus write data
- mmio_work_any  in  1  OR of all responders' mmio_work (combinational address decode)
- mmio_done_any  in  1  OR of all responders' mmio_done
- mmio_read_data_or  in  32  OR of all responders' mmio_read_data; non-selected responders drive 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, timeout count=0.
  - Outputs: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mmio_read=0, mmio_write=0, mmio_addr=0, mmio_write_data=0.
  - A reset during ACCESS or RESP aborts the access; no response is ever issued for it.
- All outputs are registered except req_ready, which is 1 iff state==IDLE and not in reset.
- IDLE:
  - Bus strobes=0, mmio_addr=32'h0. Responders must not decode address 0.
  - On req_valid at an edge: latch we/addr/wdata, drive the bus from the next cycle (mmio_read=!we, mmio_write=we), clear the count, go to ACCESS.
- ACCESS: bus signals are held stable every cycle. Evaluated at each edge in priority order:
  - mmio_done_any=1: capture resp_rdata = we ? 0 : mmio_read_data_or; resp_err=0; go to RESP.
  - mmio_work_any=0: unmapped; resp_err=1, resp_rdata=ERR_RDATA; go to RESP.
  - count==TIMEOUT-1: timeout; resp_err=1, resp_rdata=ERR_RDATA; go to RESP.
  - Otherwise: count+1 and stay in ACCESS.
  - On every exit from ACCESS, the bus is driven idle (strobes 0, addr 0, wdata 0) at that same edge.
- RESP:
  - resp_valid=1 for exactly one cycle, with rdata/err stable; bus idle; then go to IDLE.
  - resp_rdata and resp_err are cleared to 0 on the edge leaving RESP.
- Turnaround: RESP guarantees at least one idle bus cycle after done. Because a responder re-fires done whenever its address is still decoded, this idle cycle is mandatory.
- Latency, with acceptance at cycle 0:
  - Single-cycle responder: done seen in cycle 2, resp_valid in cycle 3.
  - Unmapped: resp_valid in cycle 2.
  - Timeout: resp_valid in cycle TIMEOUT+1.
  - Back-to-back throughput: one access per 4 cycles.
- Simultaneous done_any and !work_any in the same cycle: done wins (success).
- req_valid during ACCESS/RESP is ignored (req_ready=0); the CPU holds the request.

Decomposition:
- mmio_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - MMIO_BASE=32'hFFFF_0000
  - SEG7_BASE=32'hFFFF_0100
  - MMIO_IDLE_ADDR=32'h0
  - ERR_RDATA default
  - timeout counter width = $clog2(TIMEOUT)
- No sub-module is required. The response mux and timeout counter stay inline.

Test Plan:
1. Store 0x3F to 0xFFFF_0104 against the seg7 responder:
   - mmio_write high cycles 1–2.
   - seg7 register 1 = 0x3F after cycle 1.
   - resp_valid in cycle 3, resp_err=0.
   - Bus idle in cycle 3.
2. Load from 0xFFFF_0104 after test 1:
   - resp_rdata=0x0000_003F, resp_err=0, resp_valid in cycle 3.
   - mmio_read high for exactly 2 cycles.
3. Load from 0xFFFF_0400 (unmapped):
   - resp_valid in cycle 2, resp_err=1, resp_rdata=ERR_RDATA.
   - No responder sees done.
4. Stub responder with work=1 and done never asserted, TIMEOUT=16:
   - ACCESS lasts 16 cycles, resp_valid in cycle 17, resp_err=1.
   - Next request is accepted in cycle 18.
5. req_valid held high for two consecutive stores:
   - req_ready low cycles 1–3.
   - Second request accepted in cycle 4, second resp_valid in cycle 7.
   - Bus address is 0 in cycle 3.
6. rst_n pulsed low mid-ACCESS (cycle 1):
   - All outputs go to 0 immediately.
   - No resp_valid is issued.
   - req_ready=1 in the first cycle after rst_n rises.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared FSM state, address map constants and counter sizing for the MMIO initiator.
package mmio_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] MMIO_BASE      = 32'hFFFF_0000;
    localparam logic [31:0] SEG7_BASE      = 32'hFFFF_0100;
    localparam logic [31:0] MMIO_IDLE_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_ERR_RDATA  = 32'h0000_0000;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout);
    endfunction

endpackage

// File: rtl/mmio_initiator.sv
// mmio_initiator: CPU-side MMIO bus master; issues one access at a time and returns
// responder data, or an error for unmapped addresses and hung responders.
module mmio_initiator
    import mmio_pkg::*;
#(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_RDATA = DEF_ERR_RDATA
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mmio_read,
    output logic        mmio_write,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_write_data,
    input  logic        mmio_work_any,
    input  logic        mmio_done_any,
    input  logic [31:0] mmio_read_data_or
);

    localparam int           CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mmio_initiator: TIMEOUT must be >= 2");
    end

    state_t        state;
    logic [CW-1:0] count;
    logic          finish;

    // done beats an unmapped decode in the same cycle
    assign finish    = mmio_done_any || !mmio_work_any || (count == LAST);
    assign req_ready = (state == IDLE) && rst_n;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= '0;
            resp_valid      <= 1'b0;
            resp_err        <= 1'b0;
            resp_rdata      <= '0;
            mmio_read       <= 1'b0;
            mmio_write      <= 1'b0;
            mmio_addr       <= MMIO_IDLE_ADDR;
            mmio_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mmio_read       <= !req_we;
                        mmio_write      <= req_we;
                        mmio_addr       <= req_addr;
                        mmio_write_data <= req_wdata;
                        count           <= '0;
                        state           <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        resp_valid      <= 1'b1;
                        resp_err        <= !mmio_done_any;
                        resp_rdata      <= !mmio_done_any ? ERR_RDATA :
                                           mmio_write ? 32'h0 : mmio_read_data_or;
                        mmio_read       <= 1'b0;
                        mmio_write      <= 1'b0;
                        mmio_addr       <= MMIO_IDLE_ADDR;
                        mmio_write_data <= '0;
                        state           <= RESP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    // the idle bus cycle here absorbs a responder's re-fired done
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_initiator.sv
// tb_mmio_initiator: directed test of mmio_initiator against a seg7 responder, a hung stub
// and unmapped space, with a transaction-level model checked every cycle.
module tb_mmio_initiator;
    import mmio_pkg::*;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'h0000_0000;
    localparam logic [31:0] STUB_BASE = 32'hFFFF_0200;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mmio_read, mmio_write;
    logic [31:0] resp_rdata, mmio_addr, mmio_write_data;
    logic        mmio_work_any, mmio_done_any;
    logic [31:0] mmio_read_data_or;

    mmio_initiator #(.TIMEOUT(TO), .ERR_RDATA(ERR)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mmio_read(mmio_read), .mmio_write(mmio_write), .mmio_addr(mmio_addr),
        .mmio_write_data(mmio_write_data), .mmio_work_any(mmio_work_any),
        .mmio_done_any(mmio_done_any), .mmio_read_data_or(mmio_read_data_or)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // responders: seg7 (done one cycle after decode) and a stub that never completes
    logic [31:0] seg7_regs [4] = '{default: 32'h0};
    logic        seg7_done = 1'b0;
    logic        seg7_work, stub_work;
    assign seg7_work = ((mmio_addr & 32'hFFFF_FF00) == SEG7_BASE) && (mmio_read || mmio_write);
    assign stub_work = ((mmio_addr & 32'hFFFF_FF00) == STUB_BASE) && (mmio_read || mmio_write);
    assign mmio_work_any = seg7_work || stub_work;
    assign mmio_done_any = seg7_done;
    assign mmio_read_data_or = (seg7_work && mmio_read) ? seg7_regs[mmio_addr[3:2]] : 32'h0;
    always @(posedge sys_clk) begin
        seg7_done <= seg7_work;
        if (seg7_work && mmio_write) seg7_regs[mmio_addr[3:2]] <= mmio_write_data;
    end

    int n_checks = 0, n_fail = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // transaction model: one access in flight, timing from the address class
    logic [31:0] shadow [logic [31:0]];
    bit          m_active = 0;
    int          m_acc, m_lat;
    logic        m_we, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;

    function automatic int latency_of(input logic [31:0] a);
        if ((a & 32'hFFFF_FF00) == SEG7_BASE) return 3;
        if ((a & 32'hFFFF_FF00) == STUB_BASE) return TO + 1;
        return 2;
    endfunction

    always @(negedge sys_clk) begin
        int  rel;
        bit  e_busy, e_resp, e_ready;
        if (!rst_n) begin
            m_active = 0;
            check("rst_outputs", {26'b0, req_ready, resp_valid, resp_err, mmio_read, mmio_write,
                  |{resp_rdata, mmio_addr, mmio_write_data}}, 32'h0);
        end else begin
            rel     = cyc - m_acc;
            e_busy  = m_active && rel >= 1 && rel < m_lat;
            e_resp  = m_active && rel == m_lat;
            e_ready = !m_active || rel > m_lat;
            if (m_active && rel > m_lat) m_active = 0;
            check("req_ready", {31'b0, req_ready}, {31'b0, e_ready});
            check("mmio_read", {31'b0, mmio_read}, {31'b0, e_busy && !m_we});
            check("mmio_write", {31'b0, mmio_write}, {31'b0, e_busy && m_we});
            check("mmio_addr", mmio_addr, e_busy ? m_addr : 32'h0);
            check("mmio_wdata", mmio_write_data, (e_busy && m_we) ? m_wdata : 32'h0);
            check("resp_valid", {31'b0, resp_valid}, {31'b0, e_resp});
            check("resp_err", {31'b0, resp_err}, {31'b0, e_resp && m_err});
            check("resp_rdata", resp_rdata, e_resp ? m_rdata : 32'h0);
            if (e_ready && req_valid) begin
                m_active = 1;
                m_acc    = cyc;
                m_we     = req_we;
                m_addr   = req_addr;
                m_wdata  = req_wdata;
                m_lat    = latency_of(req_addr);
                m_err    = (m_lat != 3);
                if (m_err) m_rdata = ERR;
                else if (req_we) m_rdata = 32'h0;
                else m_rdata = shadow.exists(req_addr) ? shadow[req_addr] : 32'h0;
                if (!m_err && req_we) shadow[req_addr] = req_wdata;
            end
        end
    end

    int last_acc;

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int strobes, output logic idle_at_resp,
                          output logic [31:0] rd, output logic er, output logic [31:0] snap,
                          output int done_seen);
        int t0;
        bit got;
        lat = -1; strobes = 0; idle_at_resp = 0; rd = 0; er = 0; snap = 0; done_seen = 0; got = 0;
        @(posedge sys_clk); #1;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge sys_clk);
            if (req_ready) got = 1;
        end
        check("accept_bound", {31'b0, got}, 32'h1);
        t0 = cyc;
        last_acc = t0;
        @(posedge sys_clk); #1;
        req_valid = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge sys_clk);
            if (mmio_read || mmio_write) strobes++;
            if (seg7_done) done_seen++;
            if (cyc - t0 == 2) snap = seg7_regs[1];
            if (resp_valid) begin
                got = 1;
                lat = cyc - t0;
                rd = resp_rdata;
                er = resp_err;
                idle_at_resp = !mmio_read && !mmio_write && mmio_addr == 32'h0;
            end
        end
        check("resp_bound", {31'b0, got}, 32'h1);
    endtask

    initial begin
        int          lat, strobes, done_seen, t0, prev;
        logic        idle, er;
        logic [31:0] rd, snap;
        bit          got;

        repeat (3) @(negedge sys_clk);
        check("reset_ready", {31'b0, req_ready}, 32'h0);
        rst_n = 1;

        // 1: store 0x3F to seg7 register 1
        do_req(1, 32'hFFFF_0104, 32'h3F, lat, strobes, idle, rd, er, snap, done_seen);
        check("t1_lat", lat, 3);
        check("t1_strobes", strobes, 2);
        check("t1_seg7_reg1", snap, 32'h3F);
        check("t1_err", {31'b0, er}, 32'h0);
        check("t1_bus_idle", {31'b0, idle}, 32'h1);

        // 2: load it back
        do_req(0, 32'hFFFF_0104, 32'h0, lat, strobes, idle, rd, er, snap, done_seen);
        check("t2_lat", lat, 3);
        check("t2_rdata", rd, 32'h0000_003F);
        check("t2_err", {31'b0, er}, 32'h0);
        check("t2_read_cycles", strobes, 2);

        // 3: unmapped load
        do_req(0, 32'hFFFF_0400, 32'h0, lat, strobes, idle, rd, er, snap, done_seen);
        check("t3_lat", lat, 2);
        check("t3_err", {31'b0, er}, 32'h1);
        check("t3_rdata", rd, ERR);
        check("t3_no_done", done_seen, 0);

        // 4: hung responder times out; next request accepted right after
        do_req(0, 32'hFFFF_0200, 32'h0, lat, strobes, idle, rd, er, snap, done_seen);
        prev = last_acc;
        check("t4_lat", lat, 17);
        check("t4_access_cycles", strobes, 16);
        check("t4_err", {31'b0, er}, 32'h1);
        do_req(0, 32'hFFFF_0104, 32'h0, lat, strobes, idle, rd, er, snap, done_seen);
        check("t4_next_accept", last_acc - prev, 18);
        check("t4_next_rdata", rd, 32'h3F);

        // 5: req_valid held across two stores
        @(posedge sys_clk); #1;
        req_valid = 1; req_we = 1; req_addr = 32'hFFFF_0108; req_wdata = 32'hAA;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge sys_clk);
            if (req_ready) got = 1;
        end
        check("t5_accept_bound", {31'b0, got}, 32'h1);
        t0 = cyc;
        @(posedge sys_clk); #1;
        req_addr = 32'hFFFF_010C; req_wdata = 32'h55;
        for (int k = 1; k <= 4; k++) begin
            @(negedge sys_clk);
            check("t5_ready", {31'b0, req_ready}, {31'b0, k == 4});
            if (k == 3) check("t5_addr_c3", mmio_addr, 32'h0);
        end
        @(posedge sys_clk); #1;
        req_valid = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge sys_clk);
            if (resp_valid) got = 1;
        end
        check("t5_resp2_cycle", cyc - t0, 7);
        check("t5_seg7_reg3", seg7_regs[3], 32'h55);

        // 6: reset mid-ACCESS aborts without a response
        @(posedge sys_clk); #1;
        req_valid = 1; req_we = 0; req_addr = 32'hFFFF_0104;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge sys_clk);
            if (req_ready) got = 1;
        end
        @(posedge sys_clk); #1;
        req_valid = 0;
        check("t6_in_access", {31'b0, mmio_read}, 32'h1);
        #1 rst_n = 0;
        #1;
        check("t6_async_ctrl", {27'b0, req_ready, resp_valid, resp_err, mmio_read, mmio_write}, 32'h0);
        check("t6_async_data", resp_rdata | mmio_addr | mmio_write_data, 32'h0);
        @(posedge sys_clk); #2 rst_n = 1;
        @(negedge sys_clk);
        check("t6_ready_after", {31'b0, req_ready}, 32'h1);
        done_seen = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (resp_valid) done_seen++;
        end
        check("t6_no_resp", done_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
